// File: rtl/vc_test_pkg.sv
// Shared types and constants for the vc_test random-delay sink and its LFSR.
package vc_test_pkg;

    typedef enum logic {
        READY = 1'b0,
        STALL = 1'b1
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/vc_test_lfsr16.sv
// 16-bit Fibonacci LFSR that steps once per cycle while en is high.
module vc_test_lfsr16
    import vc_test_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= seed;
        end else if (en) begin
            out <= {out[14:0], ^(out & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/vc_test_rand_delay_sink.sv
// Test sink: checks incoming messages against memory m and stalls randomly after each transfer.
// Define VC_TEST_RAND_DELAY_SINK_TRACE_EN to print a trace line per transfer.
module vc_test_rand_delay_sink
    import vc_test_pkg::*;
#(
    parameter int          p_msg_sz    = 1,
    parameter int          p_mem_sz    = 1024,
    parameter int          p_max_delay = 0,
    parameter logic [15:0] p_seed      = DEFAULT_SEED
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        val,
    output logic                        rdy,
    input  logic [p_msg_sz-1:0]         msg,
    input  logic [$clog2(p_mem_sz):0]   num_msgs,
    output logic                        done,
    output logic [$clog2(p_mem_sz):0]   num_failed
);

    localparam int          AW     = $clog2(p_mem_sz) + 1;
    localparam int          IW     = (p_mem_sz > 1) ? $clog2(p_mem_sz) : 1;
    localparam logic [AW-1:0] MEM_SZ = AW'(p_mem_sz);
    localparam logic [15:0] DIV    = 16'(p_max_delay + 1);
    // A zero seed would lock the LFSR at zero forever.
    localparam logic [15:0] SEED   = (p_seed == 16'h0000) ? 16'h0001 : p_seed;

    logic [p_msg_sz-1:0] m [0:p_mem_sz-1];

    state_t              state;
    state_t              state_next;
    logic [15:0]         count;
    logic [15:0]         count_next;
    logic [AW-1:0]       index;
    logic [AW-1:0]       num_eff;
    logic [15:0]         lfsr;
    logic [15:0]         delay;
    logic [p_msg_sz-1:0] expected;
    logic                xfer;
    logic                mismatch;

    // Handshake: a message moves on a rising edge where val && rdy; rdy never depends on val.
    assign num_eff  = (num_msgs > MEM_SZ) ? MEM_SZ : num_msgs;
    assign done     = (index == num_eff);
    assign rdy      = (state == READY) && !done;
    assign xfer     = val && rdy;
    assign expected = m[index[IW-1:0]];
    assign mismatch = xfer && (msg != expected);
    assign delay    = lfsr % DIV;

    vc_test_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (xfer),
        .seed  (SEED),
        .out   (lfsr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= READY;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // count holds the stall cycles still to go, including the current one.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            READY: begin
                if (xfer && (delay != 16'd0)) begin
                    state_next = STALL;
                    count_next = delay;
                end
            end
            STALL: begin
                if (count <= 16'd1) begin
                    state_next = READY;
                    count_next = '0;
                end else begin
                    count_next = count - 16'd1;
                end
            end
            default: begin
                state_next = READY;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index      <= '0;
            num_failed <= '0;
        end else begin
            if (xfer) begin
                index <= index + AW'(1);
            end
            if (mismatch) begin
                num_failed <= num_failed + AW'(1);
            end
        end
    end

`ifdef VC_TEST_RAND_DELAY_SINK_TRACE_EN
    always @(posedge clk) begin
        if (!reset && xfer) begin
            $display("sink[%0d]: got %h expected %h", index, msg, expected);
            if (msg != expected) begin
                $display("sink[%0d]: FAILED got %h expected %h", index, msg, expected);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vc_test_rand_delay_sink.sv
// Bench for vc_test_rand_delay_sink: a zero-delay instance and a max-delay-2 instance.
module tb_vc_test_rand_delay_sink;

    localparam int MW = 8;
    localparam int MS = 16;
    localparam int AW = $clog2(MS) + 1;

    typedef struct {
        logic          rst;
        int            nm;
        logic [MW-1:0] msg;
        logic          e_rdy;
        logic          e_done;
        int            e_fail;
    } vec_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          val0  = 1'b0;
    logic          val2  = 1'b0;
    logic [MW-1:0] msg0  = '0;
    logic [MW-1:0] msg2  = '0;
    logic [AW-1:0] nm0   = AW'(6);
    logic [AW-1:0] nm2   = AW'(6);
    logic          rdy0, rdy2, done0, done2;
    logic [AW-1:0] nf0, nf2;

    int            checks = 0;
    int            errors = 0;
    logic [15:0]   exp_q[$];
    logic [MW-1:0] data [0:5];
    vec_t          vecs [0:13];
    logic          ref_pat [0:11];

    always #5 clk = ~clk;

    vc_test_rand_delay_sink #(.p_msg_sz(MW), .p_mem_sz(MS), .p_max_delay(0)) dut0 (
        .clk(clk), .reset(reset), .val(val0), .rdy(rdy0), .msg(msg0),
        .num_msgs(nm0), .done(done0), .num_failed(nf0)
    );

    vc_test_rand_delay_sink #(.p_msg_sz(MW), .p_mem_sz(MS), .p_max_delay(2)) dut2 (
        .clk(clk), .reset(reset), .val(val2), .rdy(rdy2), .msg(msg2),
        .num_msgs(nm2), .done(done2), .num_failed(nf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    // Called at a falling edge; returns at the next falling edge with reset released.
    task automatic do_reset();
        val0  = 1'b0;
        val2  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] model;
        int          sent, idle, run, cyc, n, pulses;
        logic        in_stall, finished, stalled, first, r, dn, v;

        data[0] = 8'haa; data[1] = 8'hbb; data[2] = 8'hcc;
        data[3] = 8'hdd; data[4] = 8'hee; data[5] = 8'hff;
        for (int i = 0; i < 6; i++) begin
            dut0.m[i] = data[i];
            dut2.m[i] = data[i];
        end

        vecs[0]  = '{1'b1, 6, 8'haa, 1'b1, 1'b0, 0};
        vecs[1]  = '{1'b0, 6, 8'hbb, 1'b1, 1'b0, 0};
        vecs[2]  = '{1'b0, 6, 8'hcc, 1'b1, 1'b0, 0};
        vecs[3]  = '{1'b0, 6, 8'hdd, 1'b1, 1'b0, 0};
        vecs[4]  = '{1'b0, 6, 8'hee, 1'b1, 1'b0, 0};
        vecs[5]  = '{1'b0, 6, 8'hff, 1'b1, 1'b0, 0};
        vecs[6]  = '{1'b0, 6, 8'h11, 1'b0, 1'b1, 0};
        vecs[7]  = '{1'b1, 6, 8'haa, 1'b1, 1'b0, 0};
        vecs[8]  = '{1'b0, 6, 8'hbb, 1'b1, 1'b0, 0};
        vecs[9]  = '{1'b0, 6, 8'hc0, 1'b1, 1'b0, 0};
        vecs[10] = '{1'b0, 6, 8'hdd, 1'b1, 1'b0, 1};
        vecs[11] = '{1'b0, 6, 8'hee, 1'b1, 1'b0, 1};
        vecs[12] = '{1'b0, 6, 8'hff, 1'b1, 1'b0, 1};
        vecs[13] = '{1'b0, 6, 8'h22, 1'b0, 1'b1, 1};

        // Reset state, sampled while reset is still high.
        @(negedge clk);
        check("reset_rdy", 32'(rdy0), 32'd1);
        check("reset_done", 32'(done0), 32'd0);
        check("reset_failed", 32'(nf0), 32'd0);
        check("reset_index", 32'(dut2.index), 32'd0);
        reset = 1'b0;

        // Empty run: done and not ready straight out of reset, val ignored.
        nm0 = '0;
        nm2 = '0;
        do_reset();
        #1;
        check("empty_done0", 32'(done0), 32'd1);
        check("empty_rdy0", 32'(rdy0), 32'd0);
        check("empty_done2", 32'(done2), 32'd1);
        check("empty_rdy2", 32'(rdy2), 32'd0);
        val0 = 1'b1;
        @(negedge clk);
        #1;
        check("empty_index", 32'(dut0.index), 32'd0);
        @(negedge clk);

        // Zero-delay streaming, clean and with one corrupted message.
        for (int i = 0; i < 14; i++) begin
            nm0 = AW'(vecs[i].nm);
            if (vecs[i].rst) do_reset();
            val0 = 1'b1;
            msg0 = vecs[i].msg;
            #1;
            check($sformatf("vec%0d_rdy", i), 32'(rdy0), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_done", i), 32'(done0), 32'(vecs[i].e_done));
            check($sformatf("vec%0d_failed", i), 32'(nf0), 32'(vecs[i].e_fail));
            @(negedge clk);
        end
        val0 = 1'b0;

        // Random-valid source into the delay-2 sink; stall lengths come from a reference LFSR.
        nm2 = AW'(6);
        do_reset();
        model = 16'hACE1;
        sent = 0; idle = 0; run = 0; cyc = 0;
        in_stall = 1'b0; finished = 1'b0;
        while (cyc < 40 && !finished) begin
            #1;
            r  = rdy2;
            dn = done2;
            if (in_stall) begin
                if (!r && !dn) begin
                    run++;
                end else begin
                    if (!dn) begin
                        check("stall_len", 32'(run), 32'(exp_q.pop_front()));
                        check("stall_range", 32'(run <= 2), 32'd1);
                    end else begin
                        void'(exp_q.pop_front());
                    end
                    in_stall = 1'b0;
                end
            end
            if (dn) begin
                finished = 1'b1;
            end else begin
                v = (idle >= 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (!v) idle++;
                val2 = v;
                msg2 = (sent < 6) ? data[sent] : 8'h00;
                if (v && r) begin
                    exp_q.push_back(model % 16'd3);
                    model    = lfsr_next(model);
                    sent++;
                    in_stall = 1'b1;
                    run      = 0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("rand_done_in_40", 32'(finished), 32'd1);
        check("rand_sent", 32'(sent), 32'd6);
        check("rand_failed", 32'(nf2), 32'd0);
        val2 = 1'b0;
        exp_q.delete();

        // Reference rdy pattern with val held high from reset.
        do_reset();
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            ref_pat[c] = rdy2;
            val2 = 1'b1;
            msg2 = (sent < 6) ? data[sent] : 8'h00;
            if (rdy2) sent++;
            @(negedge clk);
        end

        // Three transfers (second one wrong), then reset in the middle of the following stall.
        do_reset();
        sent = 0; n = 0; stalled = 1'b0;
        while (n < 20 && !stalled) begin
            #1;
            if (sent == 3 && !rdy2 && !done2) begin
                stalled = 1'b1;
            end else begin
                val2 = 1'b1;
                msg2 = (sent == 1) ? 8'h00 : ((sent < 6) ? data[sent] : 8'h00);
                if (rdy2) sent++;
                @(negedge clk);
                n++;
            end
        end
        check("midstall_reached", 32'(stalled), 32'd1);
        check("midstall_index", 32'(dut2.index), 32'd3);
        check("midstall_failed", 32'(nf2), 32'd1);
        reset = 1'b1;
        #1;
        check("async_index", 32'(dut2.index), 32'd0);
        check("async_failed", 32'(nf2), 32'd0);
        check("async_rdy", 32'(rdy2), 32'd1);
        check("async_count", 32'(dut2.count), 32'd0);
        val2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("replay_rdy%0d", c), 32'(rdy2), 32'(ref_pat[c]));
            val2 = 1'b1;
            msg2 = (sent < 6) ? data[sent] : 8'h00;
            if (rdy2) sent++;
            @(negedge clk);
        end
        check("replay_failed", 32'(nf2), 32'd0);

        // val raised only during stall cycles, carrying a wrong message.
        do_reset();
        first = 1'b0; pulses = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (!first && rdy2) begin
                val2  = 1'b1;
                msg2  = data[0];
                first = 1'b1;
            end else if (!rdy2 && !done2) begin
                val2 = 1'b1;
                msg2 = 8'h00;
                pulses++;
            end else begin
                val2 = 1'b0;
            end
            @(negedge clk);
        end
        val2 = 1'b0;
        check("stallval_pulses", 32'(pulses), 32'(16'hACE1 % 16'd3));
        check("stallval_index", 32'(dut2.index), 32'd1);
        check("stallval_failed", 32'(nf2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_test_rand_delay_sink.md
VC_TEST_RAND_DELAY_SINK -- requirements
Module: vc_test_rand_delay_sink

Interface
REQ-001 SHALL have parameter p_msg_sz, default 1: message width in bits.
REQ-002 SHALL have parameter p_mem_sz, default 1024: depth of the expected-message memory.
REQ-003 SHALL have parameter p_max_delay, default 0: maximum number of random stall cycles inserted after each accepted message.
REQ-004 SHALL have parameter p_seed, default 16'hACE1: LFSR reset seed, forced to 16'h0001 if given as zero.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port val, input, 1 bit: producer valid.
REQ-008 SHALL have port rdy, output, 1 bit: sink ready.
REQ-009 SHALL have port msg, input, p_msg_sz bits: incoming message.
REQ-010 SHALL have port num_msgs, input, $clog2(p_mem_sz)+1 bits: expected message count; values above p_mem_sz are treated as p_mem_sz.
REQ-011 SHALL have port done, output, 1 bit: all expected messages received.
REQ-012 SHALL have port num_failed, output, $clog2(p_mem_sz)+1 bits: count of mismatched messages.
REQ-013 SHALL have internal array m[0:p_mem_sz-1] of p_msg_sz-bit entries, loaded hierarchically by the bench and never written by the RTL.

Function
REQ-014 SHALL transfer a message only on a cycle where val && rdy, at the rising edge of clk.
REQ-015 SHALL implement a two-state FSM, READY and STALL, with rdy = (state==READY) && !done.
REQ-016 SHALL, on each transfer, compare msg with m[index], increment num_failed on inequality, and increment index.
REQ-017 SHALL, on each transfer, draw d = lfsr % (p_max_delay+1) and advance the LFSR one step.
- If d==0: stay in READY.
- Otherwise: go to STALL with the count register = d.
REQ-018 SHALL, in STALL, hold rdy=0 and decrement count each cycle, returning to READY on the cycle where count==1, so that exactly d stall cycles are inserted.
REQ-019 SHALL, when p_max_delay==0, accept one message per cycle with no stalls (zero added latency).
REQ-020 SHALL ignore val asserted during STALL or while done: no compare, index unchanged.
REQ-021 SHALL assert done combinationally when index == effective num_msgs, including num_msgs==0 immediately after reset, and SHALL then hold rdy=0.
REQ-022 SHALL use a 16-bit Fibonacci LFSR with taps 16,14,13,11 that advances only on transfers.

Reset
REQ-023 SHALL, on reset assertion, asynchronously set: state=READY, count=0, index=0, num_failed=0, lfsr=p_seed.
REQ-024 SHALL, on reset asserted mid-operation (including mid-STALL), abandon the current stall and restart the sequence from m[0] with an identical random pattern.

Configuration
REQ-025 SHALL, with VC_TEST_RAND_DELAY_SINK_TRACE_EN defined, $display on each transfer the index, received value and expected value, and on a mismatch print "FAILED" with both values.
REQ-026 SHALL, without VC_TEST_RAND_DELAY_SINK_TRACE_EN, compile with no display statements and leave cycle behaviour identical.

Structure
REQ-027 SHALL place in shared package vc_test_pkg:
- the state enum typedef (READY, STALL);
- the LFSR tap constant;
- the default-seed constant.
REQ-028 SHALL instantiate one sub-module, vc_test_lfsr16, with ports clk, reset, en, seed, and out.

Verification
REQ-029 SHALL cover: p_max_delay=0, m[0..5]=aa,bb,cc,dd,ee,ff, num_msgs=6, val held high -> 6 transfers on consecutive cycles, done=1 on cycle 6, num_failed=0.
REQ-030 SHALL cover: p_max_delay=2, same data via a random-delay source -> done within 40 cycles, num_failed=0, every stall run 0-2 cycles long.
REQ-031 SHALL cover: m[2]=cc but msg 8'hc0 sent third -> num_failed=1, done=1 after 6 transfers.
REQ-032 SHALL cover: num_msgs=0 -> done=1 and rdy=0 immediately after reset.
REQ-033 SHALL cover: reset pulsed during STALL after 3 transfers -> index=0 and num_failed=0 asynchronously, with the same rdy pattern replayed after release.
REQ-034 SHALL cover: val pulsed only during STALL cycles -> index unchanged and no compare performed.
